// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline latch.
// Owns the PC and drives the icache request. When a redirect arrives while a
// fetch is still outstanding, the returning wrong-path word is squashed.
// A decoded halt freezes fetch until reset.
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = {WORD_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pc_en,
  input  logic              stall_ifid,
  input  logic              flush_ifid,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              ifid_valid
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [WORD_W-1:0] PC_STEP = {{(WORD_W-3){1'b0}}, 3'd4};

  state_t            r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_pend_pc;

  state_t            w_state_next;
  logic [WORD_W-1:0] w_pc_next;
  logic [WORD_W-1:0] w_pend_next;
  logic [WORD_W-1:0] w_pc_plus4;
  logic              w_load;    // latch iload as a real instruction
  logic              w_bubble;  // latch a nop bubble (wrong-path word dropped)
  logic              w_halted;  // drain IF/ID valid while halted

  // PC + 4 wraps naturally modulo 2^WORD_W
  assign w_pc_plus4 = r_pc + PC_STEP;

  // The cache address is the PC register; the request drops while in reset or halted
  assign imemaddr = r_pc;
  assign imemREN  = nRST & (r_state != ST_HALTED);

  // Next-state, next-PC and IF/ID load decisions
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_pend_next  = r_pend_pc;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (halt) begin
          w_state_next = ST_HALTED;
        end else if (redirect) begin
          if (ihit) begin
            // Word returned this cycle belongs to the old path
            w_pc_next = redirect_pc;
            w_bubble  = 1'b1;
          end else begin
            // Fetch still in flight: remember target and squash its return
            w_pend_next  = redirect_pc;
            w_state_next = ST_SQUASH;
          end
        end else if (ihit && pc_en && !stall_ifid) begin
          w_pc_next = w_pc_plus4;
          w_load    = 1'b1;
        end else begin
          w_pc_next = r_pc;
        end
      end
      ST_SQUASH: begin
        if (halt) begin
          w_state_next = ST_HALTED;
        end else if (ihit) begin
          // Outstanding fetch returned; drop it and jump to the latest target
          w_pc_next    = redirect ? redirect_pc : r_pend_pc;
          w_bubble     = 1'b1;
          w_state_next = ST_FETCH;
        end else if (redirect) begin
          w_pend_next = redirect_pc;
        end else begin
          w_pend_next = r_pend_pc;
        end
      end
      ST_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // Fetch FSM, PC and pending-redirect target
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_FETCH;
      r_pc      <= PC_INIT;
      r_pend_pc <= {WORD_W{1'b0}};
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_pend_pc <= w_pend_next;
    end
  end

  // IF/ID latch: flush beats stall beats load; halt drains the valid bit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifid_instr <= {WORD_W{1'b0}};
      ifid_npc   <= {WORD_W{1'b0}};
      ifid_valid <= 1'b0;
    end else if (flush_ifid) begin
      ifid_instr <= {WORD_W{1'b0}};
      ifid_npc   <= {WORD_W{1'b0}};
      ifid_valid <= 1'b0;
    end else if (w_halted) begin
      ifid_valid <= 1'b0;
    end else if (stall_ifid) begin
      ifid_valid <= ifid_valid;
    end else if (w_load) begin
      ifid_instr <= iload;
      ifid_npc   <= w_pc_plus4;
      ifid_valid <= 1'b1;
    end else if (w_bubble) begin
      ifid_instr <= {WORD_W{1'b0}};
      ifid_npc   <= {WORD_W{1'b0}};
      ifid_valid <= 1'b0;
    end else begin
      ifid_valid <= ifid_valid;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit.
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        pc_en;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .pc_en      (pc_en),
    .stall_ifid (stall_ifid),
    .flush_ifid (flush_ifid),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .ihit       (ihit),
    .iload      (iload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ifid_instr (ifid_instr),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        pc_en;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        ihit;
    logic [31:0] iload;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ren, input logic [31:0] e_addr,
                         input logic [31:0] e_instr, input logic [31:0] e_npc, input logic e_valid);
    chk({tag, ".ren"},   {31'd0, imemREN},    {31'd0, e_ren});
    chk({tag, ".addr"},  imemaddr,            e_addr);
    chk({tag, ".instr"}, ifid_instr,          e_instr);
    chk({tag, ".npc"},   ifid_npc,            e_npc);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
  endtask

  task automatic drive(input logic pe, input logic st, input logic fl, input logic rd,
                       input logic [31:0] rp, input logic hl, input logic ih, input logic [31:0] il);
    pc_en = pe; stall_ifid = st; flush_ifid = fl; redirect = rd;
    redirect_pc = rp; halt = hl; ihit = ih; iload = il;
  endtask

  initial begin
    // pc_en stall flush redir rpc ihit iload | ren addr instr npc valid
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h2001000A, 1'b1,32'h4,        32'h2001000A,32'h4, 1'b1};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h11111111, 1'b1,32'h4,        32'h2001000A,32'h4, 1'b1};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h11111111, 1'b1,32'h4,        32'h2001000A,32'h4, 1'b1};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h22222222, 1'b1,32'h8,        32'h22222222,32'h8, 1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,32'h40,       1'b0,32'h0,        1'b1,32'h8,        32'h22222222,32'h8, 1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h8,        32'h22222222,32'h8, 1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'hDEADBEEF, 1'b1,32'h40,       32'h0,       32'h0, 1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h33333333, 1'b1,32'h44,       32'h33333333,32'h44,1'b1};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,32'h40,       1'b0,32'h0,        1'b1,32'h44,       32'h33333333,32'h44,1'b1};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,32'h80,       1'b0,32'h0,        1'b1,32'h44,       32'h33333333,32'h44,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBADBAD00, 1'b1,32'h80,       32'h0,       32'h0, 1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h44444444, 1'b1,32'h84,       32'h44444444,32'h84,1'b1};
    vecs[12] = '{1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h55555555, 1'b1,32'h84,       32'h0,       32'h0, 1'b0};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,32'hFFFFFFFC, 1'b1,32'h66666666, 1'b1,32'hFFFFFFFC, 32'h0,       32'h0, 1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h77777777, 1'b1,32'h0,        32'h77777777,32'h0, 1'b1};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h88888888, 1'b1,32'h0,        32'h77777777,32'h0, 1'b1};
    vecs[16] = '{1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        32'h0,       32'h0, 1'b0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h99999999, 1'b1,32'h4,        32'h99999999,32'h4, 1'b1};

    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    nRST = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].pc_en, vecs[i].stall, vecs[i].flush, vecs[i].redir,
            vecs[i].rpc, 1'b0, vecs[i].ihit, vecs[i].iload);
      @(negedge CLK);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ren, vecs[i].e_addr,
              vecs[i].e_instr, vecs[i].e_npc, vecs[i].e_valid);
    end

    // Halt: request drops, PC frozen, IF/ID drains on the following edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hABCDABCD);
    @(negedge CLK);
    chk_all("halt0", 1'b0, 32'h4, 32'h99999999, 32'h4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, k[0], 32'h200, 1'b0, 1'b1, 32'h12345678);
      @(negedge CLK);
      chk_all($sformatf("halted%0d", k), 1'b0, 32'h4, 32'h99999999, 32'h4, 1'b0);
    end

    // Reset from HALTED, then enter SQUASH and reset again mid-squash
    #2 nRST = 1'b0;
    #1 chk_all("rst_halt", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    chk_all("squash_in", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1 chk_all("rst_squash", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA0000);
    @(negedge CLK);
    chk_all("post_rst", 1'b1, 32'h4, 32'hAAAA0000, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID latch for the pipelined core. It acts on the hazard unit's control outputs (pc_en, stall_ifid, flush_ifid) and on branch/jump redirects, which makes it the receiving end of those signals.
It owns the PC, drives the instruction-cache request and holds the IF/ID register that feeds decode.
It also tracks a redirect that arrives while an instruction fetch is still outstanding, and discards the wrong-path word when that fetch returns.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.
WORD_W, 32, width of PC, addresses and instruction words.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
pc_en  in  1  hazard unit: PC may advance this cycle.
stall_ifid  in  1  hazard unit: hold PC and IF/ID.
flush_ifid  in  1  hazard unit: clear IF/ID to a bubble.
redirect  in  1  branch taken or jump resolved; target on redirect_pc.
redirect_pc  in  WORD_W  redirect target address.
halt  in  1  halt instruction decoded; freezes fetch until reset.
ihit  in  1  icache returns iload for imemaddr this cycle.
iload  in  WORD_W  instruction word.
imemREN  out  1  instruction read request.
imemaddr  out  WORD_W  fetch address (equals PC).
ifid_instr  out  WORD_W  latched instruction; 0 (nop) when bubble.
ifid_npc  out  WORD_W  latched PC+4 of that instruction.
ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, nRST=0, applied immediately):
  - PC=PC_INIT, state=FETCH, pend_pc=0.
  - ifid_instr=0, ifid_npc=0, ifid_valid=0.
  - imemREN is forced to 0 while nRST=0.
  - A reset mid-SQUASH or mid-HALTED abandons that state; no pending redirect survives.
- imemaddr=PC combinationally. imemREN=1 in FETCH and SQUASH, and 0 in HALTED.
- Address arithmetic is PC+4 modulo 2^WORD_W: 0xFFFFFFFC wraps to 0.
- State FETCH:
  - redirect=1 and ihit=1: PC<=redirect_pc. The returned word is wrong-path and is not latched; IF/ID receives a bubble. Stay in FETCH.
  - redirect=1 and ihit=0: pend_pc<=redirect_pc, PC holds, go to SQUASH.
  - redirect=0, ihit=1, pc_en=1, stall_ifid=0: PC<=PC+4; ifid_instr<=iload, ifid_npc<=PC+4, ifid_valid<=1.
  - ihit=1 with pc_en=0 or stall_ifid=1: PC holds and IF/ID holds. The word is refetched later.
  - ihit=0 and no redirect: PC holds and IF/ID holds.
  - halt=1 (any cycle): go to HALTED next edge. halt takes priority over redirect and over every PC update.
- State SQUASH:
  - imemREN stays 1 at the held PC so the outstanding fetch can complete.
  - A new redirect overwrites pend_pc; the latest redirect wins.
  - On ihit: the word is discarded and ifid_valid is not set. PC<=pend_pc, or redirect_pc if redirect=1 in that same cycle. Return to FETCH.
  - pc_en and stall_ifid do not delay the squash completion.
- State HALTED:
  - PC is frozen, ihit and redirect are ignored, and ifid_valid<=0 on the next edge.
  - The state is sticky until nRST.
- IF/ID update priority, evaluated every edge regardless of state: flush_ifid > stall_ifid > load.
  - flush_ifid=1: ifid_valid<=0, ifid_instr<=0, ifid_npc<=0. This applies even when stall_ifid=1 or a load would occur.
  - flush_ifid does not by itself alter PC. PC follows the pc_en, stall_ifid and redirect rules above.
- Latency: a fetch issued at PC with ihit in cycle N appears on ifid_* after edge N; imemaddr=PC+4 from cycle N+1.
- There are no combinational paths from ihit or iload to imemREN. The only combinational path to imemaddr is from the PC register.

Test Plan:
1. Release nRST, PC_INIT=0, ihit=1 with iload=0x2001000A, pc_en=1 -> after edge: ifid_instr=0x2001000A, ifid_npc=4, ifid_valid=1, imemaddr=4.
2. At PC=4, ihit=1, stall_ifid=1 for 2 cycles, then 0 -> PC stays 4 and IF/ID is unchanged during the stall; after release, ifid_npc=8 and imemaddr=8.
3. At PC=8, redirect=1 with redirect_pc=0x40 and ihit=0, then ihit=1 two cycles later -> state SQUASH, word discarded (ifid_valid=0), next imemaddr=0x40.
4. In SQUASH, a second redirect to 0x80 arrives before ihit -> after ihit, imemaddr=0x80, never 0x40.
5. flush_ifid=1 and stall_ifid=1 in the same cycle with IF/ID valid -> ifid_valid=0 and ifid_instr=0; PC is unchanged.
6. halt=1 -> imemREN=0 next cycle and PC is frozen despite ihit pulses. Separately, PC=0xFFFFFFFC with ihit -> PC=0 and ifid_npc=0. Then nRST low mid-SQUASH -> PC=PC_INIT, ifid_valid=0, state FETCH.
